serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around one fa_1bit instance and a carry flip-flop.

---
 rtl/serial_adder.sv | 158 +++++++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.

module fa_1bit (
  input  logic i0_i,
  input  logic i1_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = i0_i ^ i1_i ^ cin_i;
  assign cout_o = (i0_i & i1_i) | (i0_i & cin_i) | (i1_i & cin_i);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa_1bit u_fa (
    .i0_i   (a_sr_q[0]),
    .i1_i   (b_sr_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_sr_d  = a_i;
          b_sr_d  = b_i;
          s_sr_d  = '0;
          carry_d = cin_i;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d  = {fa_sum, s_sr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        count_d = count_q + CW'(1);
        // Last bit: carry_q is the carry into the MSB, fa_cout the carry out of it.
        if (count_q == CW'(WIDTH - 1)) begin
          sum_d   = s_sr_d;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, random adds,
// start-while-busy, mid-run reset and back-to-back issue, with a result scoreboard.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf_o   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  res_t sb_q[$];
  res_t last_res;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    res_t       r;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic check_done(input string name);
    res_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: done pulse with empty scoreboard", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_sum"}, 32'(sum), 32'(e.sum));
      check({name, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
      check({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      last_res = e;
    end
  endtask

  // One add; inj>0 pulses a zero-operand start at that cycle, rcyc>0 asserts reset then.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input res_t e, input int inj, input int rcyc, input string name);
    int cyc, busy_n, done_n;
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; a = ~x; b = ~y; cin = ~c;
    cyc = 0; busy_n = 0; done_n = 0;
    while (cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
      if (inj > 0 && cyc == inj) begin
        start = 1'b1; a = '0; b = '0; cin = 1'b0;
      end else if (inj > 0 && cyc == inj + 1) begin
        start = 1'b0;
      end
      if (rcyc > 0 && cyc == rcyc + 1) begin
        rst = 1'b0;
        check({name, "_rst_busy"}, 32'(busy), 32'd0);
        check({name, "_rst_sum"}, 32'(sum), 32'd0);
        check({name, "_rst_cout"}, 32'(cout), 32'd0);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        last_res = '0;
      end
      if (rcyc > 0 && cyc == rcyc) rst = 1'b1;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          check({name, "_latency"}, 32'(cyc), 32'(W + 1));
          check_done(name);
        end
      end else if (rcyc == 0 && cyc <= W) begin
        check({name, "_hold_sum"}, 32'(sum), 32'(last_res.sum));
        check({name, "_hold_cout"}, 32'(cout), 32'(last_res.cout));
      end
    end
    if (rcyc > 0) begin
      check({name, "_no_done"}, 32'(done_n), 32'd0);
    end else begin
      check({name, "_done_count"}, 32'(done_n), 32'd1);
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(W + 1));
      if (done_n == 0 && sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic back_to_back();
    logic [W-1:0] xs[4], ys[4];
    logic         cs[4];
    int           acc, dn, cyc, last_done;
    logic         prev_busy;
    for (int i = 0; i < 4; i++) begin
      xs[i] = W'($urandom());
      ys[i] = W'($urandom());
      cs[i] = 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    a = xs[0]; b = ys[0]; cin = cs[0]; start = 1'b1;
    sb_q.push_back(model(xs[0], ys[0], cs[0]));
    acc = 0; dn = 0; cyc = 0; last_done = 0; prev_busy = busy;
    while (dn < 4 && cyc < 4 * (W + 2) + 10) begin
      @(negedge clk);
      cyc++;
      if (busy && !prev_busy) begin
        acc++;
        if (acc < 4) begin
          a = xs[acc]; b = ys[acc]; cin = cs[acc];
          sb_q.push_back(model(xs[acc], ys[acc], cs[acc]));
        end else begin
          start = 1'b0;
        end
      end
      prev_busy = busy;
      if (done) begin
        dn++;
        check_done("b2b");
        if (dn > 1) check("b2b_interval", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
      end else if (dn > 0) begin
        check("b2b_hold_sum", 32'(sum), 32'(last_res.sum));
      end
    end
    start = 1'b0;
    check("b2b_results", 32'(dn), 32'd4);
    check("b2b_sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    vec_t tbl[9];
    res_t e;
    logic [W-1:0] rx, ry;
    logic         rc;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    check("rst_wins_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      e.sum  = tbl[i].sum;
      e.cout = tbl[i].cout;
      e.ovf  = model(tbl[i].a, tbl[i].b, tbl[i].cin).ovf;
      do_add(tbl[i].a, tbl[i].b, tbl[i].cin, e, 0, 0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rx = W'($urandom());
      ry = W'($urandom());
      rc = 1'($urandom_range(1, 0));
      do_add(rx, ry, rc, model(rx, ry, rc), 0, 0, $sformatf("rnd%0d", i));
    end

    do_add(8'h5A, 8'h3C, 1'b0, model(8'h5A, 8'h3C, 1'b0), 4, 0, "start_busy");
    do_add(8'hC3, 8'h71, 1'b1, model(8'hC3, 8'h71, 1'b1), 0, 0, "pre_abort");
    do_add(8'h33, 8'h44, 1'b0, model(8'h33, 8'h44, 1'b0), 0, 5, "abort");
    do_add(8'hFF, 8'h01, 1'b0, model(8'hFF, 8'h01, 1'b0), 0, 0, "post_abort");

    back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
